// File: rtl/operand_sm_converter_if.sv
// Operand bus between the switch/button front end and the operand converter.
// Handshake: the converter asserts out_valid with a stable operand pair; the
// pair is consumed at the first rising clk edge where out_valid & out_ready
// are both 1. out_valid never drops before that edge, and the outputs do not
// change while out_valid is high.
interface operand_sm_converter_if #(
  parameter int DW = 8
);
  logic [DW-1:0] data_in;
  logic          load;
  logic          out_ready;
  logic [DW-1:0] multiplicand_mag;
  logic [DW-1:0] multiplier_mag;
  logic          multiplicand_msb;
  logic          multiplier_msb;
  logic          sign;
  logic          out_valid;
  logic          busy;
  logic [1:0]    stage;

  // Front end / bench side: drives operands and the ready strobe.
  modport master (
    output data_in, load, out_ready,
    input  multiplicand_mag, multiplier_mag, multiplicand_msb, multiplier_msb,
    input  sign, out_valid, busy, stage
  );

  // Converter side.
  modport slave (
    input  data_in, load, out_ready,
    output multiplicand_mag, multiplier_mag, multiplicand_msb, multiplier_msb,
    output sign, out_valid, busy, stage
  );
endinterface

// File: rtl/operand_sm_converter.sv
// Captures a multiplicand and then a multiplier from a shared two's-complement
// bus, converts both to sign-magnitude in a single CONVERT cycle, and presents
// magnitudes, raw sign bits and the product sign on a valid/ready handshake.
// DW must match the DW of the connected interface instance.
module operand_sm_converter #(
  parameter int DW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  operand_sm_converter_if.slave  bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_MPLR = 2'd1;
  localparam logic [1:0] CONVERT   = 2'd2;
  localparam logic [1:0] VALID     = 2'd3;

  localparam logic [DW-1:0] ONE  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] ZERO = '0;

  logic [1:0]    state;
  logic [DW-1:0] mcand;
  logic [DW-1:0] mplr;
  logic [DW-1:0] mcand_abs;
  logic [DW-1:0] mplr_abs;
  logic          prod_sign;

  logic [DW-1:0] mcand_mag_q;
  logic [DW-1:0] mplr_mag_q;
  logic          mcand_msb_q;
  logic          mplr_msb_q;
  logic          sign_q;

  // Two's-complement to magnitude; -2^(DW-1) maps to 2^(DW-1) as an unsigned value.
  always_comb begin
    mcand_abs = mcand[DW-1] ? (~mcand + ONE) : mcand;
    mplr_abs  = mplr[DW-1]  ? (~mplr + ONE)  : mplr;
    // A zero operand always gives a zero product, which must not be negative.
    prod_sign = (mcand[DW-1] ^ mplr[DW-1]) & (mcand != ZERO) & (mplr != ZERO);
  end

  // Operand capture, conversion and handshake sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mcand       <= '0;
      mplr        <= '0;
      mcand_mag_q <= '0;
      mplr_mag_q  <= '0;
      mcand_msb_q <= 1'b0;
      mplr_msb_q  <= 1'b0;
      sign_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            mcand <= bus.data_in;
            state <= WAIT_MPLR;
          end
        end
        WAIT_MPLR: begin
          if (bus.load) begin
            mplr  <= bus.data_in;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          mcand_mag_q <= mcand_abs;
          mplr_mag_q  <= mplr_abs;
          mcand_msb_q <= mcand[DW-1];
          mplr_msb_q  <= mplr[DW-1];
          sign_q      <= prod_sign;
          state       <= VALID;
        end
        default: begin
          // VALID: loads are ignored, including one on the handshake edge.
          if (bus.out_ready) state <= IDLE;
        end
      endcase
    end
  end

  // Every output is a register or a decode of the state register.
  always_comb begin
    bus.multiplicand_mag = mcand_mag_q;
    bus.multiplier_mag   = mplr_mag_q;
    bus.multiplicand_msb = mcand_msb_q;
    bus.multiplier_msb   = mplr_msb_q;
    bus.sign             = sign_q;
    bus.out_valid        = (state == VALID);
    bus.busy             = state[1];
    bus.stage            = state;
  end

endmodule

// File: doc/operand_sm_converter.md
Name: operand_sm_converter

Overview:
- Input-side counterpart of the product sign-restoration stage.
- Captures two two's-complement operands, multiplicand first and then multiplier, from one shared data bus on successive load strobes.
- Converts each operand to sign-magnitude and hands the magnitudes and sign bits to the unsigned multiplier core over a valid/ready handshake.
- Sits between the debounced DE2-115 switch/button inputs and the multiplier.

Parameters:
DW, 8, operand width in bits (two's complement in, unsigned magnitude out)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
data_in  input  DW  two's-complement operand bus (switches)
load  input  1  one-cycle strobe (debounced upstream); captures data_in
out_ready  input  1  multiplier core accepts operands
multiplicand_mag  output  DW  |multiplicand|, unsigned
multiplier_mag  output  DW  |multiplier|, unsigned
multiplicand_msb  output  1  raw sign bit of captured multiplicand
multiplier_msb  output  1  raw sign bit of captured multiplier
sign  output  1  product sign: msb XOR msb, forced 0 if either magnitude is 0
out_valid  output  1  operand pair valid
busy  output  1  high in CONVERT and VALID
stage  output  2  state code for LEDs: 0 IDLE, 1 WAIT_MPLR, 2 CONVERT, 3 VALID

Behaviour:
- Reset, sampled at a clk edge with rst=1:
  - state=IDLE.
  - All magnitude, msb and sign outputs = 0.
  - out_valid=0, busy=0, stage=0.
  - Internal operand registers cleared.
  - rst has priority over every other input in every state; it aborts any operation in progress.
- State IDLE: load=1 at an edge -> capture data_in as multiplicand, go to WAIT_MPLR. load=0 -> stay.
- State WAIT_MPLR: load=1 at an edge -> capture data_in as multiplier, go to CONVERT. load=0 -> stay with no timeout.
- State CONVERT: exactly one cycle; load is ignored. At the exiting edge, register all of the following and go to VALID:
  - multiplicand_msb and multiplier_msb = bit DW-1 of the respective operand.
  - Magnitude = operand when msb=0, else (~operand + 1) truncated to DW bits.
  - sign = msb XOR msb, forced to 0 if either magnitude is 0 (no negative zero).
- Most-negative operand -2^(DW-1) yields magnitude 2^(DW-1), MSB set. This is a valid unsigned magnitude, not an error.
- State VALID:
  - out_valid=1; all outputs held stable until the handshake.
  - Handshake = out_valid & out_ready at an edge -> IDLE. out_valid drops the cycle after the handshake edge. Magnitude, msb and sign outputs keep their last values until the next CONVERT.
  - load in VALID is ignored. This includes load coinciding with the handshake edge; the next operand pair needs a fresh load after IDLE is reached.
- Latency: multiplier load edge -> 1 cycle CONVERT -> out_valid high after the following edge. Minimum of 3 edges from the first load to out_valid.
- out_ready is a don't-care outside VALID.
- busy=1 in CONVERT and VALID. stage reflects the current state code.
- All outputs are registered; no combinational path from any input to any output.

Test Plan (DW=8):
- rst, then load 0x05, load 0xFD, out_ready=1:
  - Outputs: multiplicand_mag=5, multiplier_mag=3, multiplicand_msb=0, multiplier_msb=1, sign=1.
  - out_valid rises 2 edges after the second load and is high for exactly 1 cycle.
- Load 0x80, load 0x80: both magnitudes=0x80, both msbs=1, sign=0.
- Load 0x00, load 0xF0: multiplicand_mag=0, multiplier_mag=0x10, multiplier_msb=1, sign=0 (zero forcing).
- Load 0x81, load 0x7F, out_ready held 0 for 5 cycles with load pulses of 0x11 during VALID:
  - Outputs stay at 0x7F/0x7F, sign=1, out_valid=1 throughout.
  - Raising out_ready completes the handshake and returns to IDLE (stage=0) with the loads ignored.
- Load 0x0A (stage=1), then rst for 1 cycle, then load 0x03, load 0x02:
  - After rst, stage=0 and all outputs are 0.
  - The new pair gives magnitudes 3/2, sign=0.
- Back-to-back: handshake edge with load=1 -> the load is ignored. The next two loads after IDLE form a correct new pair.
